// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS pixel packer: FSM encoding, geometry width,
// the default frame discard count and the byte-pair packing helper.
package cmos_pkg;

    localparam int GEOM_W = 13;

    localparam logic [3:0] WAIT_FRAME_DEFAULT = 4'd10;

    localparam logic [1:0] ST_SKIP    = 2'd0;
    localparam logic [1:0] ST_WAIT_VS = 2'd1;
    localparam logic [1:0] ST_ACTIVE  = 2'd2;

    function automatic logic [15:0] pack_pixel(input logic [7:0] first_byte,
                                               input logic [7:0] second_byte,
                                               input logic       hi_first);
        return hi_first ? {first_byte, second_byte} : {second_byte, first_byte};
    endfunction

endpackage

// File: rtl/cmos_geom_check.sv
// Frame geometry checker: counts pixels per line and lines per frame and flags
// any disagreement with the configuration latched at the start of the frame.
module cmos_geom_check
    import cmos_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [GEOM_W-1:0] cfg_h_pixel,
    input  logic [GEOM_W-1:0] cfg_v_pixel,
    input  logic              start,
    input  logic              pix_strobe,
    input  logic              line_end,
    input  logic              odd_end,
    input  logic              boundary,
    output logic              err
);

    localparam logic [GEOM_W-1:0] SAT = '1;

    logic [GEOM_W-1:0] h_cfg;
    logic [GEOM_W-1:0] v_cfg;
    logic [GEOM_W-1:0] pix_cnt;
    logic [GEOM_W-1:0] line_cnt;
    logic [GEOM_W-1:0] line_cnt_nxt;
    logic              sticky;
    logic              line_bad;
    logic              frame_bad;

    // The line closing in this cycle must be counted before the boundary compare.
    always_comb begin
        line_cnt_nxt = line_cnt;
        if (line_end && line_cnt != SAT) begin
            line_cnt_nxt = line_cnt + GEOM_W'(1);
        end
        line_bad  = line_end && (odd_end || pix_cnt != h_cfg || pix_cnt == SAT);
        frame_bad = boundary && (line_cnt_nxt != v_cfg || line_cnt_nxt == SAT);
    end

    assign err = sticky | line_bad | frame_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cfg    <= '0;
            v_cfg    <= '0;
            pix_cnt  <= '0;
            line_cnt <= '0;
            sticky   <= 1'b0;
        end else if (load) begin
            h_cfg    <= cfg_h_pixel;
            v_cfg    <= cfg_v_pixel;
            pix_cnt  <= '0;
            line_cnt <= '0;
            sticky   <= 1'b0;
        end else begin
            if (start) begin
                sticky <= 1'b0;
            end else if (line_bad || frame_bad) begin
                sticky <= 1'b1;
            end
            if (line_end) begin
                pix_cnt <= '0;
            end else if (pix_strobe && pix_cnt != SAT) begin
                pix_cnt <= pix_cnt + GEOM_W'(1);
            end
            line_cnt <= line_cnt_nxt;
        end
    end

endmodule

// File: rtl/cmos_pixel_pack.sv
// Packs 8-bit DVP camera bytes into RGB565 pixels after discarding WAIT_FRAME
// frames. Define CMOS_FRAME_CHECK_EN to enable the frame geometry checker.
module cmos_pixel_pack
    import cmos_pkg::*;
#(
    parameter logic [3:0] WAIT_FRAME    = WAIT_FRAME_DEFAULT,
    parameter logic       HI_BYTE_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    input  logic [GEOM_W-1:0] cfg_h_pixel,
    input  logic [GEOM_W-1:0] cfg_v_pixel,
    output logic              pix_valid,
    output logic [15:0]       pix_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              frame_err
);

    logic       vs_r;
    logic       hr_r;
    logic [7:0] d_r;
    logic       vs_prev;
    logic       hq_prev;
    logic       hr_q;
    logic       boundary;
    logic       vs_fall;
    logic       hq_rise;
    logic       pair_done;
    logic       start_now;
    logic       active;

    logic [1:0] state;
    logic [3:0] frame_cnt;
    logic       phase;
    logic       started;
    logic [7:0] first_byte;
    logic       geom_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_r    <= 1'b0;
            hr_r    <= 1'b0;
            d_r     <= 8'h00;
            vs_prev <= 1'b0;
            hq_prev <= 1'b0;
        end else begin
            vs_r    <= cam_vsync;
            hr_r    <= cam_href;
            d_r     <= cam_data;
            vs_prev <= vs_r;
            hq_prev <= hr_q;
        end
    end

    // Line valid is only honoured outside vertical blanking.
    assign hr_q      = hr_r & ~vs_r;
    assign boundary  = vs_r & ~vs_prev;
    assign vs_fall   = ~vs_r & vs_prev;
    assign hq_rise   = hr_q & ~hq_prev;
    assign active    = (state == ST_ACTIVE);
    assign pair_done = hr_q & phase;
    assign start_now = active & hq_rise & ~started;

    // The first boundary after reset only opens the first complete frame, so
    // the discard count closes on the boundary after the counter reaches WAIT_FRAME.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_SKIP;
            frame_cnt   <= 4'd0;
            phase       <= 1'b0;
            started     <= 1'b0;
            first_byte  <= 8'h00;
            pix_valid   <= 1'b0;
            pix_data    <= 16'h0000;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            phase       <= hr_q ? ~phase : 1'b0;
            if (hr_q && !phase) begin
                first_byte <= d_r;
            end
            case (state)
                ST_SKIP: begin
                    if (WAIT_FRAME == 4'd0) begin
                        state <= ST_WAIT_VS;
                    end else if (boundary) begin
                        if (frame_cnt == WAIT_FRAME) begin
                            state <= ST_WAIT_VS;
                        end else begin
                            frame_cnt <= frame_cnt + 4'd1;
                        end
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_fall) begin
                        state   <= ST_ACTIVE;
                        started <= 1'b0;
                    end
                end
                ST_ACTIVE: begin
                    if (boundary) begin
                        state      <= ST_WAIT_VS;
                        frame_done <= 1'b1;
                        frame_err  <= geom_err;
                    end
                    if (start_now) begin
                        started     <= 1'b1;
                        frame_start <= 1'b1;
                    end
                    if (pair_done) begin
                        pix_valid <= 1'b1;
                        pix_data  <= pack_pixel(first_byte, d_r, HI_BYTE_FIRST);
                    end
                end
                default: state <= ST_SKIP;
            endcase
        end
    end

`ifdef CMOS_FRAME_CHECK_EN
    logic hq_fall;
    logic odd_end;

    assign hq_fall = ~hr_q & hq_prev;
    assign odd_end = hq_fall & phase;

    cmos_geom_check u_geom (
        .clk         (clk),
        .rst         (rst),
        .load        ((state == ST_WAIT_VS) && vs_fall),
        .cfg_h_pixel (cfg_h_pixel),
        .cfg_v_pixel (cfg_v_pixel),
        .start       (start_now),
        .pix_strobe  (active & pair_done),
        .line_end    (active & hq_fall),
        .odd_end     (active & odd_end),
        .boundary    (active & boundary),
        .err         (geom_err)
    );
`else
    logic cfg_unused;

    assign cfg_unused = ^{cfg_h_pixel, cfg_v_pixel};
    assign geom_err   = 1'b0;
`endif

endmodule

// File: tb/tb_cmos_pixel_pack.sv
// Self-checking bench for cmos_pixel_pack: two instances (high/low byte first)
// share one randomized camera stream checked against a frame-level model.
module tb_cmos_pixel_pack;
    import cmos_pkg::*;

    localparam logic [3:0] WAIT_N = 4'd2;
`ifdef CMOS_FRAME_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic [GEOM_W-1:0] cfg_h_pixel;
    logic [GEOM_W-1:0] cfg_v_pixel;

    logic        pv_a, fs_a, fd_a, fe_a;
    logic [15:0] pd_a;
    logic        pv_b, fs_b, fd_b, fe_b;
    logic [15:0] pd_b;

    always #5 clk = ~clk;

    cmos_pixel_pack #(.WAIT_FRAME(WAIT_N), .HI_BYTE_FIRST(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .cfg_h_pixel(cfg_h_pixel), .cfg_v_pixel(cfg_v_pixel),
        .pix_valid(pv_a), .pix_data(pd_a), .frame_start(fs_a),
        .frame_done(fd_a), .frame_err(fe_a)
    );

    cmos_pixel_pack #(.WAIT_FRAME(WAIT_N), .HI_BYTE_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .cfg_h_pixel(cfg_h_pixel), .cfg_v_pixel(cfg_v_pixel),
        .pix_valid(pv_b), .pix_data(pd_b), .frame_start(fs_b),
        .frame_done(fd_b), .frame_err(fe_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] obs_a[$];
    logic [15:0] obs_b[$];
    int          obs_cyc_a[$];
    int          obs_cyc_b[$];
    int          start_a, start_b, done_a, done_b;
    logic        err_a, err_b;

    int          bcount;
    int          model_h, model_v;
    int          line_len[$];
    logic [7:0]  force_bytes[$];
    logic [7:0]  exp_first[$];
    logic [7:0]  exp_second[$];
    int          exp_cyc[$];
    int          exp_start, exp_done;
    logic        exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pv_a) begin obs_a.push_back(pd_a); obs_cyc_a.push_back(cyc); end
        if (pv_b) begin obs_b.push_back(pd_b); obs_cyc_b.push_back(cyc); end
        if (fs_a) start_a++;
        if (fs_b) start_b++;
        if (fd_a) begin done_a++; err_a = fe_a; end
        if (fd_b) begin done_b++; err_b = fe_b; end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clearObs();
        obs_a.delete(); obs_b.delete(); obs_cyc_a.delete(); obs_cyc_b.delete();
        start_a = 0; start_b = 0; done_a = 0; done_b = 0;
        err_a = 1'b0; err_b = 1'b0;
    endtask

    task automatic setLines(input int n, input int len);
        line_len.delete();
        repeat (n) line_len.push_back(len);
    endtask

    // A boundary; the cfg present when vsync drops applies to the following frame.
    task automatic vsyncPulse(input int next_h, input int next_v, input bit glitch);
        @(negedge clk);
        cam_vsync = 1'b1;
        cam_href  = 1'b0;
        bcount++;
        @(negedge clk);
        cfg_h_pixel = GEOM_W'(next_h);
        cfg_v_pixel = GEOM_W'(next_v);
        if (glitch) begin
            cam_href = 1'b1; cam_data = 8'hA5;
            @(negedge clk);
            cam_data = 8'h5A;
            @(negedge clk);
            cam_href = 1'b0;
        end else begin
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        cam_vsync = 1'b0;
        model_h   = next_h;
        model_v   = next_v;
        repeat (4) @(negedge clk);
    endtask

    task automatic applyStimulus(input int next_h, input int next_v, input bit glitch);
        bit         enabled;
        bit         bad;
        logic [7:0] prev;
        enabled = (bcount > int'(WAIT_N));
        bad     = 1'b0;
        prev    = 8'h00;
        exp_first.delete(); exp_second.delete(); exp_cyc.delete();
        foreach (line_len[l]) begin
            if ((line_len[l] % 2) != 0 || (line_len[l] / 2) != model_h) bad = 1'b1;
            for (int b = 0; b < line_len[l]; b++) begin
                @(negedge clk);
                cam_href = 1'b1;
                cam_data = (force_bytes.size() > 0) ? force_bytes.pop_front() : 8'($urandom);
                if ((b % 2) == 1 && enabled) begin
                    exp_first.push_back(prev);
                    exp_second.push_back(cam_data);
                    exp_cyc.push_back(cyc + 2);
                end
                prev = cam_data;
            end
            @(negedge clk);
            cam_href = 1'b0;
            repeat (3) @(negedge clk);
        end
        if (line_len.size() != model_v) bad = 1'b1;
        exp_done  = enabled ? 1 : 0;
        exp_start = (enabled && line_len.size() > 0) ? 1 : 0;
        exp_err   = enabled && bad && CHECK_ON;
        vsyncPulse(next_h, next_v, glitch);
    endtask

    task automatic checkFrame(input string tag);
        checkOutput({tag, "/count_hi"}, obs_a.size(), exp_first.size());
        checkOutput({tag, "/count_lo"}, obs_b.size(), exp_first.size());
        foreach (exp_first[i]) begin
            if (i < obs_a.size()) begin
                checkOutput($sformatf("%s/pix%0d_hi", tag, i), obs_a[i], {exp_first[i], exp_second[i]});
                checkOutput($sformatf("%s/lat%0d_hi", tag, i), obs_cyc_a[i], exp_cyc[i]);
            end
            if (i < obs_b.size()) begin
                checkOutput($sformatf("%s/pix%0d_lo", tag, i), obs_b[i], {exp_second[i], exp_first[i]});
            end
        end
        checkOutput({tag, "/start"}, start_a, exp_start);
        checkOutput({tag, "/start_lo"}, start_b, exp_start);
        checkOutput({tag, "/done"}, done_a, exp_done);
        checkOutput({tag, "/done_lo"}, done_b, exp_done);
        if (exp_done != 0) begin
            checkOutput({tag, "/err"}, err_a, exp_err);
            checkOutput({tag, "/err_lo"}, err_b, exp_err);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "/pv_hi"}, pv_a, 0);
        checkOutput({tag, "/pd_hi"}, pd_a, 0);
        checkOutput({tag, "/fs_hi"}, fs_a, 0);
        checkOutput({tag, "/fd_hi"}, fd_a, 0);
        checkOutput({tag, "/fe_hi"}, fe_a, 0);
        checkOutput({tag, "/pv_lo"}, pv_b, 0);
        checkOutput({tag, "/pd_lo"}, pd_b, 0);
        checkOutput({tag, "/fs_lo"}, fs_b, 0);
        checkOutput({tag, "/fd_lo"}, fd_b, 0);
        checkOutput({tag, "/fe_lo"}, fe_b, 0);
    endtask

    initial begin
        int nh, nv, nl;
        rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
        cfg_h_pixel = '0; cfg_v_pixel = '0;
        bcount = 0; model_h = 0; model_v = 0;
        clearObs();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;
        clearObs();

        vsyncPulse(4, 3, 1'b0);
        for (int f = 1; f <= 2; f++) begin
            setLines(3, 8);
            applyStimulus(4, 3, 1'b0);
            checkFrame($sformatf("discard%0d", f));
            clearObs();
        end
        setLines(3, 8);
        applyStimulus(4, 3, 1'b0);
        checkFrame("first_enabled");
        checkOutput("first_enabled/pixels12", obs_a.size(), 12);
        clearObs();

        force_bytes.push_back(8'hF8);
        force_bytes.push_back(8'h1F);
        line_len.delete();
        line_len.push_back(7); line_len.push_back(8); line_len.push_back(8);
        applyStimulus(4, 3, 1'b0);
        checkFrame("odd_line");
        checkOutput("odd_line/pixels11", obs_a.size(), 11);
        if (obs_a.size() > 0) checkOutput("pair_hi_first", obs_a[0], 16'hF81F);
        if (obs_b.size() > 0) checkOutput("pair_lo_first", obs_b[0], 16'h1FF8);
        checkOutput("odd_line/err_flag", err_a, CHECK_ON);
        clearObs();

        setLines(2, 8);
        applyStimulus(4, 3, 1'b1);
        checkFrame("short_frame_glitch");
        checkOutput("short_frame/err_flag", err_a, CHECK_ON);
        clearObs();

        line_len.delete();
        applyStimulus(3, 2, 1'b0);
        checkFrame("empty_frame");
        clearObs();

        for (int r = 0; r < 6; r++) begin
            nh = $urandom_range(1, 5);
            nv = $urandom_range(1, 3);
            nl = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : model_v;
            line_len.delete();
            for (int l = 0; l < nl; l++) begin
                line_len.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 2 * model_h);
            end
            applyStimulus(nh, nv, 1'b0);
            checkFrame($sformatf("random%0d", r));
            clearObs();
        end

        for (int b = 0; b < 10; b++) begin
            @(negedge clk);
            cam_href = 1'b1;
            cam_data = 8'($urandom);
        end
        @(negedge clk);
        cam_href = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midframe_reset");
        checkOutput("midframe_reset/pixels5", obs_a.size(), 5);
        @(negedge clk);
        rst = 1'b0;
        bcount = 0;
        clearObs();

        vsyncPulse(4, 3, 1'b0);
        for (int f = 1; f <= 3; f++) begin
            setLines(3, 8);
            applyStimulus(4, 3, 1'b0);
            checkFrame($sformatf("after_reset%0d", f));
            clearObs();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
